// File: rtl/onehot_step_sequencer_pkg.sv
// onehot_step_sequencer_pkg: default step-index width and step-count derivation shared by control-unit blocks
package onehot_step_sequencer_pkg;
   localparam int DEFAULT_WIDTH = 3;
   function automatic int num_steps(input int width);
      return 1 << width;
   endfunction
endpackage

// File: rtl/decoder_n_to_onehot.sv
// decoder_n_to_onehot: gated 1-of-N decode; binary selects one_hot[binary] (index 0 is the MSB), enable=0 forces all zeros
module decoder_n_to_onehot
   import onehot_step_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0]            binary,
   input  logic                        enable,
   output logic [0:num_steps(WIDTH)-1] one_hot
);
   always_comb begin
      one_hot = '0;
      one_hot[binary] = enable;
   end
endmodule

// File: rtl/onehot_step_sequencer.sv
// onehot_step_sequencer: up/down step counter 0..LAST with clear/load, wrap pulse, sticky load_error and gated one-hot decode
// Ports: clock/reset (async, active high); clear > load > step control; down selects direction;
//        enable gates one_hot only; binary is the registered step index; wrap pulses after a wrapping step.
module onehot_step_sequencer
   import onehot_step_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LAST  = num_steps(WIDTH) - 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        load,
   input  logic [WIDTH-1:0]            load_value,
   input  logic                        step,
   input  logic                        down,
   input  logic                        enable,
   output logic [WIDTH-1:0]            binary,
   output logic [0:num_steps(WIDTH)-1] one_hot,
   output logic                        wrap,
   output logic                        load_error
);
   localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
   logic [WIDTH-1:0] binary_next;
   logic wrap_next, error_next, at_last, at_zero, over;
   assign at_last = binary == LAST_V;
   assign at_zero = binary == '0;
   // compared as int so the range test stays meaningful when LAST is the top code
   assign over = int'(load_value) > LAST;
   always_comb begin
      binary_next = binary;
      wrap_next = 1'b0;
      error_next = load_error;
      if (clear) begin
         binary_next = '0;
         error_next = 1'b0;
      end else if (load) begin
         binary_next = over ? '0 : load_value;
         error_next = load_error | over;
      end else if (step) begin
         binary_next = down ? (at_zero ? LAST_V : binary - WIDTH'(1)) : (at_last ? '0 : binary + WIDTH'(1));
         wrap_next = down ? at_zero : at_last;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         binary <= '0;
         wrap <= 1'b0;
         load_error <= 1'b0;
      end else begin
         binary <= binary_next;
         wrap <= wrap_next;
         load_error <= error_next;
      end
   end
   decoder_n_to_onehot #(.WIDTH(WIDTH)) u_decode (
      .binary (binary),
      .enable (enable),
      .one_hot(one_hot)
   );
endmodule

// File: tb/tb_onehot_step_sequencer.sv
// tb_onehot_step_sequencer: scoreboard bench for three sequencer configurations (W3/L5, W4/L15, W2/L0)
module tb_onehot_step_sequencer;
   typedef struct {
      string nm;
      int    id;
      int    bin;
      logic  en;
      logic  w;
      logic  er;
   } exp_t;
   logic clk = 1'b0;
   logic reset, clear, load, step, down, enable;
   logic [3:0] lv;
   logic [2:0] b0;
   logic [0:7] oh0;
   logic w0, er0;
   logic [3:0] b1;
   logic [0:15] oh1;
   logic w1, er1;
   logic [1:0] b2;
   logic [0:3] oh2;
   logic w2, er2;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   logic [15:0] seen = '0;
   int wraps4 = 0;
   always #10 clk = ~clk;
   onehot_step_sequencer #(.WIDTH(3), .LAST(5)) dut0 (
      .clock(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv[2:0]), .step(step),
      .down(down), .enable(enable), .binary(b0), .one_hot(oh0), .wrap(w0), .load_error(er0)
   );
   onehot_step_sequencer #(.WIDTH(4), .LAST(15)) dut1 (
      .clock(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv), .step(step),
      .down(down), .enable(enable), .binary(b1), .one_hot(oh1), .wrap(w1), .load_error(er1)
   );
   onehot_step_sequencer #(.WIDTH(2), .LAST(0)) dut2 (
      .clock(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv[1:0]), .step(step),
      .down(down), .enable(enable), .binary(b2), .one_hot(oh2), .wrap(w2), .load_error(er2)
   );
   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask
   // monitor: every observation point pops pending expectations and compares the selected DUT
   initial begin
      exp_t e;
      logic [31:0] ab, ao;
      logic aw, ae;
      int n;
      forever begin
         @(posedge clk or posedge reset);
         #3;
         while (q.size() > 0) begin
            e = q.pop_front();
            if (e.id == 0) begin
               ab = 32'(b0); ao = 32'(oh0); aw = w0; ae = er0; n = 8;
            end else if (e.id == 1) begin
               ab = 32'(b1); ao = 32'(oh1); aw = w1; ae = er1; n = 16;
            end else begin
               ab = 32'(b2); ao = 32'(oh2); aw = w2; ae = er2; n = 4;
            end
            cmp(e.nm, "binary", ab, e.bin);
            cmp(e.nm, "one_hot", ao, e.en ? (32'd1 << (n - 1 - e.bin)) : 32'd0);
            cmp(e.nm, "wrap", {31'd0, aw}, {31'd0, e.w});
            cmp(e.nm, "load_error", {31'd0, ae}, {31'd0, e.er});
            if (e.id == 1 && e.nm == "w4_up") begin
               seen |= oh1;
               wraps4 += int'(w1);
            end
         end
      end
   end
   // one clocked cycle: drive controls, expect the post-edge state of one DUT
   task automatic cyc(input string nm, input logic c, input logic l, input logic s, input logic d, input logic e,
                      input logic [3:0] v, input int id, input int bin, input logic w, input logic er);
      clear = c; load = l; step = s; down = d; enable = e; lv = v;
      @(posedge clk);
      #1 q.push_back('{nm, id, bin, e, w, er});
      @(negedge clk);
      clear = 1'b0; load = 1'b0; step = 1'b0; down = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      clear = 0; load = 0; step = 0; down = 0; enable = 1; lv = 0; reset = 0;
      #1;
      q.push_back('{"reset0", 0, 0, 1'b1, 1'b0, 1'b0});
      q.push_back('{"reset1", 1, 0, 1'b1, 1'b0, 1'b0});
      q.push_back('{"reset2", 2, 0, 1'b1, 1'b0, 1'b0});
      reset = 1;
      @(negedge clk);
      enable = 0; step = 1; load = 1; lv = 4'd3;
      #1 q.push_back('{"reset_hold_en0", 0, 0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      reset = 0; step = 0; load = 0; enable = 1;
      for (int i = 1; i <= 6; i++) cyc("up_seq", 0, 0, 1, 0, 1, 0, 0, i % 6, i == 6, 0);
      cyc("wrap_once", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("down_wrap", 0, 0, 1, 1, 1, 0, 0, 5, 1, 0);
      cyc("hold5", 0, 0, 0, 0, 1, 0, 0, 5, 0, 0);
      cyc("down_step", 0, 0, 1, 1, 1, 0, 0, 4, 0, 0);
      cyc("load2", 0, 1, 0, 0, 1, 4'd2, 0, 2, 0, 0);
      cyc("load_over_step", 0, 1, 1, 0, 1, 4'd4, 0, 4, 0, 0);
      cyc("load_oor7", 0, 1, 0, 0, 1, 4'd7, 0, 0, 0, 1);
      cyc("err_sticky_step", 0, 0, 1, 0, 1, 0, 0, 1, 0, 1);
      cyc("err_sticky_idle", 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
      cyc("err_sticky_load", 0, 1, 0, 0, 1, 4'd3, 0, 3, 0, 1);
      cyc("clear_wins", 1, 1, 1, 0, 1, 4'd1, 0, 0, 0, 0);
      cyc("load_last", 0, 1, 0, 0, 1, 4'd5, 0, 5, 0, 0);
      cyc("up_from_last", 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
      cyc("load_oor6", 0, 1, 0, 0, 1, 4'd6, 0, 0, 0, 1);
      cyc("clear_err", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("load3", 0, 1, 0, 0, 1, 4'd3, 0, 3, 0, 0);
      cyc("en0_hold", 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
      cyc("en0_step", 0, 0, 1, 0, 0, 0, 0, 4, 0, 0);
      cyc("en0_step", 0, 0, 1, 0, 0, 0, 0, 5, 0, 0);
      cyc("en0_wrap", 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc("pre_rst_err", 0, 1, 0, 0, 1, 4'd7, 0, 0, 0, 1);
      cyc("pre_rst_load", 0, 1, 0, 0, 1, 4'd3, 0, 3, 0, 1);
      #2;
      q.push_back('{"async_reset", 0, 0, 1'b1, 1'b0, 1'b0});
      step = 1;
      reset = 1;
      @(negedge clk);
      reset = 0; step = 0;
      cyc("post_reset_step", 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
      cyc("w4_clear", 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      for (int i = 1; i <= 16; i++) cyc("w4_up", 0, 0, 1, 0, 1, 0, 1, i % 16, i == 16, 0);
      cyc("w4_idle", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("l0_clear", 1, 0, 0, 0, 1, 0, 2, 0, 0, 0);
      cyc("l0_up", 0, 0, 1, 0, 1, 0, 2, 0, 1, 0);
      cyc("l0_up2", 0, 0, 1, 0, 1, 0, 2, 0, 1, 0);
      cyc("l0_down", 0, 0, 1, 1, 1, 0, 2, 0, 1, 0);
      cyc("l0_idle", 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
      cyc("l0_load_oor", 0, 1, 0, 0, 1, 4'd1, 2, 0, 0, 1);
      cyc("l0_en0", 0, 0, 0, 0, 0, 0, 2, 0, 0, 1);
      @(posedge clk);
      #5;
      cmp("w4_visit", "seen", {16'd0, seen}, 32'h0000ffff);
      cmp("w4_visit", "wrap_count", wraps4, 1);
      cmp("scoreboard", "pending", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
